clint_timer_unit: RTL and testbench

Multi-hart machine timer and software-interrupt unit: the parametrised successor to the single-hart CSR↔CLINT timer path. Holds the shared 64-bit `mtime` with a programmable prescaler, and per hart `mtimecmp` and `msip`. Evaluates per-hart `mtip` and the Sstc `stip` against each hart's `stimecmp` CSR. Sits between the memory-mapped peripheral bus and the per-hart CSR files.

---
 rtl/clint_timer_unit_pkg.sv | 41 ++++
 rtl/clint_timer_unit_hart_timer.sv | 59 +++++
 rtl/clint_timer_unit.sv | 171 +++++++++++++++++
 tb/tb_clint_timer_unit.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/clint_timer_unit_pkg.sv
// Shared address map, reset constants and bus-side types for the CLINT timer unit.
package clint_timer_unit_pkg;

  localparam int unsigned MAX_HART = 16;
  localparam int unsigned HIDX_W   = 4;

  localparam logic [15:0] MSIP_BASE     = 16'h0000;
  localparam logic [15:0] MTIMECMP_BASE = 16'h4000;
  localparam logic [15:0] MTIME_OFS     = 16'hBFF8;

  localparam logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

  typedef enum logic [1:0] {
    SEL_NONE,
    SEL_MSIP,
    SEL_MTIMECMP,
    SEL_MTIME
  } clint_sel_e;

  typedef struct packed {
    logic        we;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
  } clint_req_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] rdata;
  } clint_rsp_t;

  function automatic logic [63:0] apply_wstrb(input logic [63:0] old_val,
                                               input logic [63:0] wdata,
                                               input logic [7:0]  wstrb);
    logic [63:0] res;
    for (int b = 0; b < 8; b++) begin
      res[b*8 +: 8] = wstrb[b] ? wdata[b*8 +: 8] : old_val[b*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/clint_timer_unit_hart_timer.sv
// Per-hart state: mtimecmp, msip and the registered mtip/stip comparators.
module clint_hart_timer
  import clint_timer_unit_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cmp_we_i,
  input  logic [63:0] cmp_wdata_i,
  input  logic [7:0]  cmp_wstrb_i,
  input  logic        msip_we_i,
  input  logic        msip_wdata_i,
  input  logic [63:0] mtime_i,
  input  logic [63:0] stimecmp_i,
  input  logic        stce_i,
  output logic [63:0] mtimecmp_o,
  output logic        msip_o,
  output logic        mtip_o,
  output logic        stip_o
);

  logic [63:0] mtimecmp_q, mtimecmp_d;
  logic        msip_q, msip_d;
  logic        mtip_q, mtip_d;
  logic        stip_q, stip_d;

  always_comb begin
    mtimecmp_d = mtimecmp_q;
    msip_d     = msip_q;
    if (cmp_we_i) begin
      mtimecmp_d = apply_wstrb(mtimecmp_q, cmp_wdata_i, cmp_wstrb_i);
    end
    if (msip_we_i) begin
      msip_d = msip_wdata_i;
    end
    // Compare against the current registered operands, so a new mtimecmp shows up one clock later.
    mtip_d = (mtime_i >= mtimecmp_q);
    stip_d = stce_i & (mtime_i >= stimecmp_i);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mtimecmp_q <= MTIMECMP_RST;
      msip_q     <= 1'b0;
      mtip_q     <= 1'b0;
      stip_q     <= 1'b0;
    end else begin
      mtimecmp_q <= mtimecmp_d;
      msip_q     <= msip_d;
      mtip_q     <= mtip_d;
      stip_q     <= stip_d;
    end
  end

  assign mtimecmp_o = mtimecmp_q;
  assign msip_o     = msip_q;
  assign mtip_o     = mtip_q;
  assign stip_o     = stip_q;

endmodule

// File: rtl/clint_timer_unit.sv
// Multi-hart CLINT: bus decode, response register, prescaled shared mtime,
// and one clint_hart_timer per hart.
module clint_timer_unit
  import clint_timer_unit_pkg::*;
#(
  parameter int unsigned NHART    = 1,
  parameter int unsigned TICK_DIV = 1,
  parameter int unsigned ADDR_W   = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   req_valid_i,
  output logic                   req_ready_o,
  input  logic                   req_we_i,
  input  logic [ADDR_W-1:0]      req_addr_i,
  input  logic [63:0]            req_wdata_i,
  input  logic [7:0]             req_wstrb_i,
  output logic                   rsp_valid_o,
  input  logic                   rsp_ready_i,
  output logic [63:0]            rsp_rdata_o,
  input  logic                   time_halt_i,
  input  logic                   csr_time_we_i,
  input  logic [63:0]            csr_time_wdata_i,
  input  logic [NHART-1:0][63:0] stimecmp_i,
  input  logic [NHART-1:0]       menvcfg_stce_i,
  output logic [63:0]            mtime_o,
  output logic [NHART-1:0]       mtip_o,
  output logic [NHART-1:0]       stip_o,
  output logic [NHART-1:0]       msip_o
);

  localparam int unsigned DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

  clint_req_t req;
  clint_rsp_t rsp_q, rsp_d;

  logic [63:0]      mtime_q, mtime_d;
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;

  clint_sel_e        sel;
  logic [HIDX_W-1:0] hart_idx;
  logic [ADDR_W-1:0] addr_msip, addr_cmp;
  logic              req_fire, wr_fire, mtime_wr;
  logic [63:0]       rd_data;

  logic [NHART-1:0][63:0] mtimecmp_arr;
  logic [NHART-1:0]       cmp_we, msip_we;
  logic                   msip_wbit;

  assign req = '{we: req_we_i, wdata: req_wdata_i, wstrb: req_wstrb_i};

  assign req_ready_o = !rsp_q.valid | rsp_ready_i;
  assign req_fire    = req_valid_i & req_ready_o;
  assign wr_fire     = req_fire & req.we;

  // Region offsets wrap below the base, so a single upper-bound compare covers each window.
  assign addr_msip = req_addr_i - ADDR_W'(MSIP_BASE);
  assign addr_cmp  = req_addr_i - ADDR_W'(MTIMECMP_BASE);

  always_comb begin
    sel      = SEL_NONE;
    hart_idx = '0;
    if (req_addr_i == ADDR_W'(MTIME_OFS)) begin
      sel = SEL_MTIME;
    end else if ((addr_msip < ADDR_W'(4 * NHART)) && (addr_msip[1:0] == 2'b00)) begin
      sel      = SEL_MSIP;
      hart_idx = addr_msip[5:2];
    end else if ((addr_cmp < ADDR_W'(8 * NHART)) && (addr_cmp[2:0] == 3'b000)) begin
      sel      = SEL_MTIMECMP;
      hart_idx = addr_cmp[6:3];
    end
  end

  assign mtime_wr = wr_fire & (sel == SEL_MTIME);

  // msip sits in the 32-bit lane picked by addr[2]; only that lane's low byte strobe counts.
  assign msip_wbit = req_addr_i[2] ? req.wdata[32] : req.wdata[0];

  for (genvar h = 0; h < NHART; h++) begin : g_hart
    logic lane_strb;
    assign lane_strb  = req_addr_i[2] ? req.wstrb[4] : req.wstrb[0];
    assign cmp_we[h]  = wr_fire & (sel == SEL_MTIMECMP) & (hart_idx == HIDX_W'(h));
    assign msip_we[h] = wr_fire & (sel == SEL_MSIP) & (hart_idx == HIDX_W'(h)) & lane_strb;

    clint_hart_timer u_hart (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .cmp_we_i     (cmp_we[h]),
      .cmp_wdata_i  (req.wdata),
      .cmp_wstrb_i  (req.wstrb),
      .msip_we_i    (msip_we[h]),
      .msip_wdata_i (msip_wbit),
      .mtime_i      (mtime_q),
      .stimecmp_i   (stimecmp_i[h]),
      .stce_i       (menvcfg_stce_i[h]),
      .mtimecmp_o   (mtimecmp_arr[h]),
      .msip_o       (msip_o[h]),
      .mtip_o       (mtip_o[h]),
      .stip_o       (stip_o[h])
    );
  end

  always_comb begin
    rd_data = '0;
    case (sel)
      SEL_MTIME: rd_data = mtime_q;
      SEL_MTIMECMP: begin
        for (int h = 0; h < NHART; h++) begin
          if (hart_idx == HIDX_W'(h)) rd_data = mtimecmp_arr[h];
        end
      end
      SEL_MSIP: begin
        for (int h = 0; h < NHART; h++) begin
          if (hart_idx == HIDX_W'(h)) begin
            if (req_addr_i[2]) rd_data[32] = msip_o[h];
            else               rd_data[0]  = msip_o[h];
          end
        end
      end
      default: rd_data = '0;
    endcase
  end

  always_comb begin
    rsp_d = rsp_q;
    if (req_fire) begin
      rsp_d.valid = 1'b1;
      rsp_d.rdata = req.we ? 64'd0 : rd_data;
    end else if (rsp_ready_i) begin
      rsp_d.valid = 1'b0;
    end
  end

  // Bus write beats CSR write beats the prescaled increment; any write restarts the prescaler.
  always_comb begin
    mtime_d   = mtime_q;
    div_cnt_d = div_cnt_q;
    if (mtime_wr) begin
      mtime_d   = apply_wstrb(mtime_q, req.wdata, req.wstrb);
      div_cnt_d = '0;
    end else if (csr_time_we_i) begin
      mtime_d   = csr_time_wdata_i;
      div_cnt_d = '0;
    end else if (!time_halt_i) begin
      if (div_cnt_q == DIV_LAST) begin
        div_cnt_d = '0;
        mtime_d   = mtime_q + 64'd1;
      end else begin
        div_cnt_d = div_cnt_q + DIV_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rsp_q     <= '0;
      mtime_q   <= '0;
      div_cnt_q <= '0;
    end else begin
      rsp_q     <= rsp_d;
      mtime_q   <= mtime_d;
      div_cnt_q <= div_cnt_d;
    end
  end

  assign rsp_valid_o = rsp_q.valid;
  assign rsp_rdata_o = rsp_q.rdata;
  assign mtime_o     = mtime_q;

endmodule

// File: tb/tb_clint_timer_unit.sv
// Directed bench: two DUTs (TICK_DIV=1 and TICK_DIV=4) share every input.
module tb_clint_timer_unit;

  localparam int unsigned NH = 2;

  logic               clk = 1'b0;
  logic               rst;
  logic               req_valid, req_we, rsp_ready;
  logic [15:0]        req_addr;
  logic [63:0]        req_wdata;
  logic [7:0]         req_wstrb;
  logic               time_halt, csr_time_we;
  logic [63:0]        csr_time_wdata;
  logic [NH-1:0][63:0] stimecmp;
  logic [NH-1:0]      stce;

  logic               a_req_ready, a_rsp_valid, b_req_ready, b_rsp_valid;
  logic [63:0]        a_rsp_rdata, b_rsp_rdata, a_mtime, b_mtime;
  logic [NH-1:0]      a_mtip, a_stip, a_msip, b_mtip, b_stip, b_msip;

  int n_checks = 0;
  int n_fail   = 0;
  logic [63:0] rd;

  always #5 clk = ~clk;

  clint_timer_unit #(.NHART(NH), .TICK_DIV(1), .ADDR_W(16)) u_dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(a_req_ready), .req_we_i(req_we),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_wstrb_i(req_wstrb),
    .rsp_valid_o(a_rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(a_rsp_rdata),
    .time_halt_i(time_halt), .csr_time_we_i(csr_time_we), .csr_time_wdata_i(csr_time_wdata),
    .stimecmp_i(stimecmp), .menvcfg_stce_i(stce),
    .mtime_o(a_mtime), .mtip_o(a_mtip), .stip_o(a_stip), .msip_o(a_msip)
  );

  clint_timer_unit #(.NHART(NH), .TICK_DIV(4), .ADDR_W(16)) u_div (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(b_req_ready), .req_we_i(req_we),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_wstrb_i(req_wstrb),
    .rsp_valid_o(b_rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(b_rsp_rdata),
    .time_halt_i(time_halt), .csr_time_we_i(csr_time_we), .csr_time_wdata_i(csr_time_wdata),
    .stimecmp_i(stimecmp), .menvcfg_stce_i(stce),
    .mtime_o(b_mtime), .mtip_o(b_mtip), .stip_o(b_stip), .msip_o(b_msip)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drive at a negedge, accepted at the next posedge, return at the following negedge.
  task automatic bus(input logic we, input logic [15:0] addr, input logic [63:0] wdata,
                     input logic [7:0] wstrb, output logic [63:0] rdata);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_wstrb = wstrb;
    @(negedge clk);
    req_valid = 1'b0;
    req_we    = 1'b0;
    check("rsp_valid", {63'd0, a_rsp_valid}, 64'd1);
    rdata = a_rsp_rdata;
    if (we) check("wr_rdata", rdata, 64'd0);
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    req_wstrb = '0; rsp_ready = 1'b1; time_halt = 1'b0; csr_time_we = 1'b0;
    csr_time_wdata = '0; stimecmp[0] = '1; stimecmp[1] = '1; stce = '0;
    cycles(3);
    rst = 1'b0;
    check("rst_mtime", a_mtime, 64'd0);
    check("rst_mtime_div", b_mtime, 64'd0);
    check("rst_mtip", {62'd0, a_mtip}, 64'd0);
    check("rst_stip", {62'd0, a_stip}, 64'd0);
    check("rst_msip", {62'd0, a_msip}, 64'd0);
    check("rst_rsp_valid", {63'd0, a_rsp_valid}, 64'd0);
    check("rst_rsp_rdata", a_rsp_rdata, 64'd0);
    check("rst_req_ready", {63'd0, a_req_ready}, 64'd1);
    cycles(4);
    check("inc_mtime", a_mtime, 64'd4);
    check("inc_mtime_div", b_mtime, 64'd1);

    bus(1'b0, 16'h4008, '0, '0, rd);  check("rd_cmp1_rst", rd, 64'hFFFF_FFFF_FFFF_FFFF);
    bus(1'b0, 16'h4010, '0, '0, rd);  check("rd_cmp_oob", rd, 64'd0);
    bus(1'b0, 16'h0008, '0, '0, rd);  check("rd_msip_oob", rd, 64'd0);
    bus(1'b0, 16'h1234, '0, '0, rd);  check("rd_unmapped", rd, 64'd0);
    check("idle_mtip", {62'd0, a_mtip}, 64'd0);
    check("idle_stip", {62'd0, a_stip}, 64'd0);

    bus(1'b1, 16'h4000, 64'h0000_0000_0000_55AB, 8'h01, rd);
    bus(1'b0, 16'h4000, '0, '0, rd);  check("cmp0_strb", rd, 64'hFFFF_FFFF_FFFF_FFAB);
    bus(1'b1, 16'h4000, '1, 8'hFF, rd);

    bus(1'b1, 16'h0004, 64'h0000_0001_0000_0000, 8'h10, rd);
    check("msip1_set", {62'd0, a_msip}, 64'd2);
    bus(1'b1, 16'h0000, 64'd1, 8'h01, rd);
    check("msip0_set", {62'd0, a_msip}, 64'd3);
    bus(1'b1, 16'h0000, 64'd0, 8'h10, rd);
    check("msip0_wrong_lane", {62'd0, a_msip}, 64'd3);
    bus(1'b0, 16'h0000, '0, '0, rd);  check("rd_msip0", rd, 64'd1);

    // Prescaler wrap with TICK_DIV=4.
    bus(1'b1, 16'hBFF8, 64'hFFFF_FFFF_FFFF_FFFE, 8'hFF, rd);
    check("div_wr", b_mtime, 64'hFFFF_FFFF_FFFF_FFFE);
    cycles(7);  check("div_pre_wrap", b_mtime, 64'hFFFF_FFFF_FFFF_FFFF);
    cycles(1);  check("div_wrap", b_mtime, 64'd0);

    bus(1'b1, 16'hBFF8, 64'hFFFF_FFFF_FFFF_FFFE, 8'hFF, rd);
    cycles(2);
    time_halt = 1'b1;
    cycles(3);
    time_halt = 1'b0;
    check("halt_div", b_mtime, 64'hFFFF_FFFF_FFFF_FFFE);
    check("halt_fast", a_mtime, 64'd0);
    cycles(5);  check("halt_pre_wrap", b_mtime, 64'hFFFF_FFFF_FFFF_FFFF);
    cycles(1);  check("halt_wrap", b_mtime, 64'd0);

    // mtip rises one clock after mtime reaches mtimecmp.
    bus(1'b1, 16'hBFF8, 64'd90, 8'hFF, rd);
    bus(1'b1, 16'h4008, 64'd100, 8'hFF, rd);
    cycles(9);
    check("mtip_at_100_mtime", a_mtime, 64'd100);
    check("mtip_at_100", {62'd0, a_mtip}, 64'd0);
    cycles(1);
    check("mtip_after_100", {62'd0, a_mtip}, 64'd2);

    // Sstc stip gated by stce.
    bus(1'b1, 16'hBFF8, 64'd200, 8'hFF, rd);
    stimecmp[0] = 64'd50;
    cycles(1);  check("stip_stce0", {62'd0, a_stip}, 64'd0);
    stce = 2'b11;
    cycles(1);  check("stip_stce1", {62'd0, a_stip}, 64'd1);
    stimecmp[0] = 64'd204;
    cycles(2);
    check("stip_edge_mtime", a_mtime, 64'd204);
    check("stip_below", {62'd0, a_stip}, 64'd0);
    cycles(1);  check("stip_equal", {62'd0, a_stip}, 64'd1);
    stce = 2'b00;
    cycles(1);  check("stip_gate_off", {62'd0, a_stip}, 64'd0);

    // Bus write beats CSR write in the same cycle; prescaler restarts.
    csr_time_we = 1'b1;
    csr_time_wdata = 64'h2000;
    bus(1'b1, 16'hBFF8, 64'h1000, 8'hFF, rd);
    csr_time_we = 1'b0;
    check("prio_mtime", a_mtime, 64'h1000);
    check("prio_mtime_div", b_mtime, 64'h1000);
    cycles(3);  check("prio_div_hold", b_mtime, 64'h1000);
    cycles(1);
    check("prio_div_tick", b_mtime, 64'h1001);
    check("prio_fast_tick", a_mtime, 64'h1004);
    csr_time_we = 1'b1;
    cycles(1);
    csr_time_we = 1'b0;
    check("csr_time", a_mtime, 64'h2000);
    bus(1'b1, 16'hBFF8, 64'hAAAA_5555_1234_5678, 8'h0F, rd);
    check("mtime_strb", a_mtime, 64'h0000_0000_1234_5678);

    // Response back-pressure, then reset mid-response.
    bus(1'b1, 16'hBFF8, 64'h500, 8'hFF, rd);
    cycles(1);
    rsp_ready = 1'b0;
    bus(1'b0, 16'hBFF8, '0, '0, rd);
    check("bp_rd", rd, 64'h501);
    for (int i = 0; i < 3; i++) begin
      check("bp_rsp_valid", {63'd0, a_rsp_valid}, 64'd1);
      check("bp_rsp_rdata", a_rsp_rdata, 64'h501);
      check("bp_req_ready", {63'd0, a_req_ready}, 64'd0);
      cycles(1);
    end
    rst = 1'b1;
    cycles(1);
    check("rst_mid_rsp_valid", {63'd0, a_rsp_valid}, 64'd0);
    check("rst_mid_rdata", a_rsp_rdata, 64'd0);
    check("rst_mid_mtime", a_mtime, 64'd0);
    check("rst_mid_msip", {62'd0, a_msip}, 64'd0);
    rst = 1'b0;
    rsp_ready = 1'b1;
    bus(1'b0, 16'h4008, '0, '0, rd);
    check("post_rst_cmp1", rd, 64'hFFFF_FFFF_FFFF_FFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1);
  end

endmodule
